// File: rtl/vx_split_join_ctrl_pkg.sv
// Shared types for the warp split/join controller.
//   state_t     : controller FSM encoding (IDLE -> EXEC -> RESP -> IDLE)
//   stk_entry_t : one IPDOM stack entry, packed {tmask, pc}, at default widths
// Width localparams give the defaults used by the controller and its interface.
package vx_split_join_ctrl_pkg;

   localparam int NUM_THREADS_DEF = 4;
   localparam int PC_WIDTH_DEF    = 32;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic [NUM_THREADS_DEF-1:0] tmask;
      logic [PC_WIDTH_DEF-1:0]    pc;
   } stk_entry_t;

endpackage

// File: rtl/vx_split_join_ctrl_if.sv
// Request / response / stack-peer bundle for vx_split_join_ctrl.
//   req_*  : split/join request, valid/ready handshake
//   rsp_*  : one-cycle response pulse, no backpressure
//   stk_*  : strobes and data toward the external IPDOM stack, top-of-stack
//            view (stk_d, stk_index, stk_empty, stk_full) back from it
// Modports: slave = the controller, master = its environment (warp + stack).
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both 1; the requester holds req_* stable while req_valid=1
// and req_ready=0. rsp_valid is a single-cycle pulse the consumer must take.
interface vx_split_join_ctrl_if #(
   parameter int NUM_THREADS = vx_split_join_ctrl_pkg::NUM_THREADS_DEF,
   parameter int PC_WIDTH    = vx_split_join_ctrl_pkg::PC_WIDTH_DEF
);
   localparam int EW = NUM_THREADS + PC_WIDTH;

   logic                   req_valid;
   logic                   req_ready;
   logic                   req_is_join;
   logic [NUM_THREADS-1:0] req_pred;
   logic [PC_WIDTH-1:0]    req_else_pc;

   logic                   rsp_valid;
   logic [NUM_THREADS-1:0] rsp_tmask;
   logic                   rsp_redirect;
   logic [PC_WIDTH-1:0]    rsp_pc;
   logic                   rsp_divergent;

   logic                   stk_push;
   logic                   stk_pop;
   logic                   stk_pair;
   logic [EW-1:0]          stk_q1;
   logic [EW-1:0]          stk_q2;
   logic [EW-1:0]          stk_d;
   logic                   stk_index;
   logic                   stk_empty;
   logic                   stk_full;

   modport slave (
      input  req_valid, req_is_join, req_pred, req_else_pc,
      output req_ready,
      output rsp_valid, rsp_tmask, rsp_redirect, rsp_pc, rsp_divergent,
      output stk_push, stk_pop, stk_pair, stk_q1, stk_q2,
      input  stk_d, stk_index, stk_empty, stk_full
   );

   modport master (
      output req_valid, req_is_join, req_pred, req_else_pc,
      input  req_ready,
      input  rsp_valid, rsp_tmask, rsp_redirect, rsp_pc, rsp_divergent,
      input  stk_push, stk_pop, stk_pair, stk_q1, stk_q2,
      output stk_d, stk_index, stk_empty, stk_full
   );

endinterface

// File: rtl/vx_split_join_ctrl.sv
// Warp split/join controller. Accepts one split or join request at a time,
// issues a single push or pop toward the external IPDOM stack, updates the
// warp thread mask and returns a one-cycle response.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   bus (slave)   : request, response and stack-peer signals
//   tmask         : current warp thread mask (all ones after reset)
//   err_overflow  : sticky, a split found the stack full
//   err_underflow : sticky, a join found the stack empty
//   dbg_state     : current FSM state
// Timing: accept edge -> EXEC cycle (stack strobe) -> RESP cycle (rsp_valid).
module vx_split_join_ctrl
   import vx_split_join_ctrl_pkg::*;
#(
   parameter int NUM_THREADS = NUM_THREADS_DEF,
   parameter int PC_WIDTH    = PC_WIDTH_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   vx_split_join_ctrl_if.slave    bus,
   output logic [NUM_THREADS-1:0] tmask,
   output logic                   err_overflow,
   output logic                   err_underflow,
   output state_t                 dbg_state
);

   localparam int EW = NUM_THREADS + PC_WIDTH;

   // Same {tmask, pc} layout as stk_entry_t, sized by this instance.
   typedef struct packed {
      logic [NUM_THREADS-1:0] tmask;
      logic [PC_WIDTH-1:0]    pc;
   } entry_t;

   state_t state_q, state_d;

   // Registered request
   logic                   is_join_q;
   logic [NUM_THREADS-1:0] pred_q;
   logic [PC_WIDTH-1:0]    else_pc_q;

   logic [NUM_THREADS-1:0] tmask_q;
   logic                   err_ovf_q, err_unf_q;

   // Response fields captured at the end of EXEC, shown only in RESP
   logic [NUM_THREADS-1:0] rsp_tmask_q;
   logic                   rsp_redir_q;
   logic [PC_WIDTH-1:0]    rsp_pc_q;
   logic                   rsp_div_q;

   // EXEC-cycle decisions
   entry_t                 stk_top;
   logic [NUM_THREADS-1:0] taken, els, tmask_nxt;
   logic                   push_c, pop_c, pair_c, redir_c, div_c, ovf_c, unf_c;
   logic [EW-1:0]          q1_c, q2_c;
   logic [PC_WIDTH-1:0]    pc_c;

   wire accept = bus.req_valid && (state_q == S_IDLE);

   assign stk_top = entry_t'(bus.stk_d);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (bus.req_valid) state_d = S_EXEC;
         S_EXEC:  state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- EXEC datapath ----------------
   always_comb begin
      taken     = tmask_q & pred_q;
      els       = tmask_q & ~pred_q;
      push_c    = 1'b0;
      pop_c     = 1'b0;
      pair_c    = 1'b0;
      q1_c      = '0;
      q2_c      = '0;
      tmask_nxt = tmask_q;
      redir_c   = 1'b0;
      pc_c      = '0;
      div_c     = 1'b0;
      ovf_c     = 1'b0;
      unf_c     = 1'b0;
      if (state_q == S_EXEC) begin
         if (!is_join_q) begin
            if (bus.stk_full) begin
               ovf_c = 1'b1;
            end else begin
               push_c = 1'b1;
               // Reconvergence entry restores the pre-split mask; its pc is unused.
               q1_c   = {tmask_q, {PC_WIDTH{1'b0}}};
               if ((taken != '0) && (els != '0)) begin
                  pair_c    = 1'b1;
                  q2_c      = {els, else_pc_q};
                  tmask_nxt = taken;
                  div_c     = 1'b1;
               end else if (taken == '0) begin
                  // Nobody takes the branch: whole warp jumps to the else path.
                  redir_c = 1'b1;
                  pc_c    = else_pc_q;
               end
            end
         end else begin
            if (bus.stk_empty) begin
               unf_c = 1'b1;
            end else begin
               pop_c     = 1'b1;
               tmask_nxt = stk_top.tmask;
               // index 0 is the else-path entry: resume at its pc.
               if (!bus.stk_index) begin
                  redir_c = 1'b1;
                  pc_c    = stk_top.pc;
               end
            end
         end
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         is_join_q   <= 1'b0;
         pred_q      <= '0;
         else_pc_q   <= '0;
         tmask_q     <= '1;
         err_ovf_q   <= 1'b0;
         err_unf_q   <= 1'b0;
         rsp_tmask_q <= '0;
         rsp_redir_q <= 1'b0;
         rsp_pc_q    <= '0;
         rsp_div_q   <= 1'b0;
      end else begin
         if (accept) begin
            is_join_q <= bus.req_is_join;
            pred_q    <= bus.req_pred;
            else_pc_q <= bus.req_else_pc;
         end
         if (state_q == S_EXEC) begin
            tmask_q     <= tmask_nxt;
            rsp_tmask_q <= tmask_nxt;
            rsp_redir_q <= redir_c;
            rsp_pc_q    <= pc_c;
            rsp_div_q   <= div_c;
         end
         if (ovf_c) err_ovf_q <= 1'b1;
         if (unf_c) err_unf_q <= 1'b1;
      end
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      bus.req_ready     = (state_q == S_IDLE);
      bus.rsp_valid     = 1'b0;
      bus.rsp_tmask     = '0;
      bus.rsp_redirect  = 1'b0;
      bus.rsp_pc        = '0;
      bus.rsp_divergent = 1'b0;
      if (state_q == S_RESP) begin
         bus.rsp_valid     = 1'b1;
         bus.rsp_tmask     = rsp_tmask_q;
         bus.rsp_redirect  = rsp_redir_q;
         bus.rsp_pc        = rsp_pc_q;
         bus.rsp_divergent = rsp_div_q;
      end
      // Strobe/data are only non-zero in EXEC; q1/q2/pair already zero without push.
      bus.stk_push = push_c;
      bus.stk_pop  = pop_c;
      bus.stk_pair = pair_c;
      bus.stk_q1   = q1_c;
      bus.stk_q2   = q2_c;
   end

   assign tmask         = tmask_q;
   assign err_overflow  = err_ovf_q;
   assign err_underflow = err_unf_q;
   assign dbg_state     = state_q;

endmodule
